// File: rtl/writeback_sequencer.sv
// Multicycle write-back select sequencer: accepts one request, optionally performs a memory read,
// then drives the write-back select and register write. Optional stall counter: WB_STALL_CNT_EN.
module writeback_sequencer #(
    parameter int MEM_LAT = 2,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_req,
    input  logic [3:0] wb_src,
    input  logic [4:0] wb_rd,
    input  logic       mem_ready,
    output logic       busy,
    output logic       mem_read,
    output logic       mdr_load,
    output logic [3:0] mem_to_reg,
    output logic       reg_write,
    output logic [4:0] write_reg,
    output logic       wb_done,
    output logic       wb_err
`ifdef WB_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAT_C = CW'(MEM_LAT);
    localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MEM_REQ  = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_MDR_LD   = 3'd3,
        ST_WRITE    = 3'd4,
        ST_ERR      = 3'd5
    } state_t;

    state_t        state_r;
    logic [3:0]    src_r;
    logic [4:0]    rd_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_inc_s;
    logic          src_mem_s;

    // Wait counter value for the cycle being evaluated, and memory-sourced decode of the request
    assign cnt_inc_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    assign src_mem_s = (wb_src == 4'd1) || (wb_src == 4'd7) || (wb_src == 4'd8);

    // Sequencer FSM; outputs are registered alongside the state they belong to
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            src_r      <= 4'd0;
            rd_r       <= 5'd0;
            cnt_r      <= {CW{1'b0}};
            busy       <= 1'b0;
            mem_read   <= 1'b0;
            mdr_load   <= 1'b0;
            mem_to_reg <= 4'd0;
            reg_write  <= 1'b0;
            write_reg  <= 5'd0;
            wb_done    <= 1'b0;
            wb_err     <= 1'b0;
        end else begin
            mem_read  <= 1'b0;
            mdr_load  <= 1'b0;
            reg_write <= 1'b0;
            wb_done   <= 1'b0;
            wb_err    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (wb_req) begin
                        src_r <= wb_src;
                        rd_r  <= wb_rd;
                        busy  <= 1'b1;
                        if (src_mem_s) begin
                            state_r    <= ST_MEM_REQ;
                            mem_read   <= 1'b1;
                            mem_to_reg <= wb_src;
                            write_reg  <= wb_rd;
                        end else if (wb_src <= 4'd8) begin
                            state_r    <= ST_WRITE;
                            mem_to_reg <= wb_src;
                            write_reg  <= wb_rd;
                            reg_write  <= (wb_rd != 5'd0);
                            wb_done    <= 1'b1;
                        end else begin
                            state_r    <= ST_ERR;
                            mem_to_reg <= 4'd0;
                            write_reg  <= 5'd0;
                            wb_err     <= 1'b1;
                        end
                    end else begin
                        state_r    <= ST_IDLE;
                        busy       <= 1'b0;
                        mem_to_reg <= 4'd0;
                        write_reg  <= 5'd0;
                    end
                end
                ST_MEM_REQ: begin
                    state_r <= ST_MEM_WAIT;
                    cnt_r   <= {CW{1'b0}};
                end
                ST_MEM_WAIT: begin
                    cnt_r <= cnt_inc_s;
                    // Data arriving on the final allowed cycle still beats the timeout
                    if ((cnt_inc_s >= LAT_C) && mem_ready) begin
                        state_r  <= ST_MDR_LD;
                        mdr_load <= 1'b1;
                    end else if (cnt_inc_s >= TMO_C) begin
                        state_r    <= ST_ERR;
                        mem_to_reg <= 4'd0;
                        write_reg  <= 5'd0;
                        wb_err     <= 1'b1;
                    end else begin
                        state_r <= ST_MEM_WAIT;
                    end
                end
                ST_MDR_LD: begin
                    state_r   <= ST_WRITE;
                    reg_write <= (rd_r != 5'd0);
                    wb_done   <= 1'b1;
                end
                ST_WRITE, ST_ERR: begin
                    state_r    <= ST_IDLE;
                    busy       <= 1'b0;
                    mem_to_reg <= 4'd0;
                    write_reg  <= 5'd0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy       <= 1'b0;
                    mem_to_reg <= 4'd0;
                    write_reg  <= 5'd0;
                end
            endcase
        end
    end

`ifdef WB_STALL_CNT_EN
    // Saturating count of cycles spent waiting on memory
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if ((state_r == ST_MEM_WAIT) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end else begin
            stall_cnt <= stall_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_sequencer.sv
// Self-checking bench for writeback_sequencer: transaction-level expectation model plus
// per-cycle compare process and literal latency checks.
module tb_writeback_sequencer;

    localparam int MEM_LAT = 2;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wb_req = 1'b0;
    logic [3:0] wb_src = 4'd0;
    logic [4:0] wb_rd = 5'd0;
    logic       mem_ready = 1'b0;
    logic       busy, mem_read, mdr_load, reg_write, wb_done, wb_err;
    logic [3:0] mem_to_reg;
    logic [4:0] write_reg;
`ifdef WB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    writeback_sequencer #(.MEM_LAT(MEM_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wb_req(wb_req), .wb_src(wb_src), .wb_rd(wb_rd),
        .mem_ready(mem_ready), .busy(busy), .mem_read(mem_read), .mdr_load(mdr_load),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .write_reg(write_reg),
        .wb_done(wb_done), .wb_err(wb_err)
`ifdef WB_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       busy, mrd, mld, rw, done, err;
        logic [3:0] m2r;
        logic [4:0] wr;
        bit         chk_wr;
        bit         is_wait;
        int         stall;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   edge_no = 0;
    int   done_edge = -1;
    int   req_edge = 0;
    int   stall_m = 0;

    function automatic exp_t mk(logic b, logic mrd, logic mld, logic [3:0] m2r, logic rw,
                                logic [4:0] wr, logic done, logic err, bit chk_wr, bit is_wait);
        exp_t e;
        e.busy = b; e.mrd = mrd; e.mld = mld; e.m2r = m2r; e.rw = rw; e.wr = wr;
        e.done = done; e.err = err; e.chk_wr = chk_wr; e.is_wait = is_wait; e.stall = 0;
        return e;
    endfunction

    function automatic exp_t idle_v();
        return mk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    // Per-cycle compare against the model queue
    always @(posedge clk) begin
        exp_t e;
        bit   bad;
        #1;
        edge_no++;
        if ((wb_done || wb_err) && done_edge < 0) done_edge = edge_no;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            bad = (busy !== e.busy) || (mem_read !== e.mrd) || (mdr_load !== e.mld) ||
                  (mem_to_reg !== e.m2r) || (reg_write !== e.rw) || (wb_done !== e.done) ||
                  (wb_err !== e.err) || (e.chk_wr && (write_reg !== e.wr));
`ifdef WB_STALL_CNT_EN
            if (stall_cnt !== 16'(e.stall)) bad = 1'b1;
`endif
            if (bad) begin
                n_fail++;
                $display("FAIL cycle%0d: got busy=%b rd=%b ld=%b m2r=%0d rw=%b wr=%0d done=%b err=%b; want busy=%b rd=%b ld=%b m2r=%0d rw=%b wr=%0d done=%b err=%b stall=%0d",
                         edge_no, busy, mem_read, mdr_load, mem_to_reg, reg_write, write_reg,
                         wb_done, wb_err, e.busy, e.mrd, e.mld, e.m2r, e.rw, e.wr, e.done,
                         e.err, e.stall);
            end
        end
    end

    task automatic check_lit(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, expv);
        end
    endtask

    // Memory readiness at wait-cycle index i
    function automatic bit rdy(int i, int rdy_from, bit early0);
        return (i >= 0) && ((i >= rdy_from) || (early0 && i == 0));
    endfunction

    // Build the expected output list for one request, then drive it edge by edge
    task automatic txn(input logic [3:0] src, input logic [4:0] rd, input int rdy_from,
                       input bit early0, input bit hold_req, input int abort_at);
        exp_t e[$];
        int   ready_at;
        int   w;
        bit   is_mem;
        is_mem = (src == 4'd1) || (src == 4'd7) || (src == 4'd8);
        if (src > 4'd8) begin
            e.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        end else if (!is_mem) begin
            e.push_back(mk(1'b1, 1'b0, 1'b0, src, rd != 5'd0, rd, 1'b1, 1'b0, 1'b1, 1'b0));
        end else begin
            e.push_back(mk(1'b1, 1'b1, 1'b0, src, 1'b0, rd, 1'b0, 1'b0, 1'b0, 1'b0));
            ready_at = MEM_LAT - 1;
            while (ready_at < TIMEOUT && !rdy(ready_at, rdy_from, early0)) ready_at++;
            w = (ready_at < TIMEOUT) ? ready_at + 1 : TIMEOUT;
            for (int i = 0; i < w; i++)
                e.push_back(mk(1'b1, 1'b0, 1'b0, src, 1'b0, rd, 1'b0, 1'b0, 1'b0, 1'b1));
            if (ready_at < TIMEOUT) begin
                e.push_back(mk(1'b1, 1'b0, 1'b1, src, 1'b0, rd, 1'b0, 1'b0, 1'b0, 1'b0));
                e.push_back(mk(1'b1, 1'b0, 1'b0, src, rd != 5'd0, rd, 1'b1, 1'b0, 1'b1, 1'b0));
            end else begin
                e.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
            end
        end
        done_edge = -1;
        for (int j = 0; j < e.size(); j++) begin
            exp_t v;
            @(negedge clk);
            if (j == 0) req_edge = edge_no + 1;
            wb_req    = (j == 0) || hold_req;
            wb_src    = (j == 0) ? src : 4'd0;
            wb_rd     = (j == 0) ? rd : 5'd3;
            mem_ready = (j < 2) ? (rdy_from == 0) : rdy(j - 2, rdy_from, early0);
            if (j > 0 && e[j-1].is_wait) stall_m++;
            if (j == abort_at) begin
                reset = 1'b1;
                stall_m = 0;
                v = idle_v();
                v.stall = stall_m;
                exp_q.push_back(v);
                break;
            end
            v = e[j];
            v.stall = stall_m;
            exp_q.push_back(v);
        end
        @(negedge clk);
        reset = 1'b0; wb_req = 1'b0; mem_ready = 1'b0; wb_src = 4'd0; wb_rd = 5'd0;
        begin
            exp_t v;
            v = idle_v();
            v.stall = stall_m;
            exp_q.push_back(v);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            exp_t v;
            @(negedge clk);
            reset = 1'b1;
            v = idle_v();
            exp_q.push_back(v);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(idle_v());

        txn(4'd0, 5'd8, 1000, 1'b0, 1'b0, -1);
        check_lit("lat_alu", done_edge - req_edge + 1, 1);
        txn(4'd1, 5'd9, 0, 1'b0, 1'b0, -1);
        check_lit("lat_mdr", done_edge - req_edge + 1, 5);
`ifdef WB_STALL_CNT_EN
        check_lit("stall_after_mdr", stall_m, 2);
`endif
        txn(4'd7, 5'd5, 5, 1'b1, 1'b0, -1);
        check_lit("lat_byte_late", done_edge - req_edge + 1, 9);
        txn(4'd8, 5'd6, 1000, 1'b0, 1'b0, -1);
        check_lit("lat_timeout", done_edge - req_edge + 1, 18);
        txn(4'd9, 5'd3, 1000, 1'b0, 1'b0, -1);
        check_lit("lat_illegal", done_edge - req_edge + 1, 1);
        txn(4'd4, 5'd0, 1000, 1'b0, 1'b0, -1);
        txn(4'd1, 5'd4, 1000, 1'b0, 1'b0, 5);
        check_lit("abort_no_done", done_edge, -1);
        txn(4'd8, 5'd17, 3, 1'b0, 1'b1, -1);
        check_lit("lat_hold_req", done_edge - req_edge + 1, 7);
        txn(4'd5, 5'd31, 1000, 1'b0, 1'b0, -1);
        txn(4'd2, 5'd1, 1000, 1'b0, 1'b0, -1);
        txn(4'd6, 5'd2, 1000, 1'b0, 1'b0, -1);
        txn(4'd3, 5'd30, 1000, 1'b0, 1'b0, -1);
        txn(4'd1, 5'd12, 15, 1'b0, 1'b0, -1);
        check_lit("lat_ready_at_timeout", done_edge - req_edge + 1, 19);
        txn(4'd7, 5'd13, 16, 1'b0, 1'b0, -1);
        check_lit("lat_ready_too_late", done_edge - req_edge + 1, 18);
        txn(4'd15, 5'd7, 1000, 1'b0, 1'b0, -1);
        txn(4'd10, 5'd7, 1000, 1'b0, 1'b0, -1);
        repeat (3) @(negedge clk);
        check_lit("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
